// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time loader for the instruction memory. Accepts a program image as a
// byte stream (valid/ready), assembles little-endian 32-bit words, writes them
// to the instruction memory and holds the core in reset until the full image
// has been written and its 8-bit payload checksum matches.
//
// Image: 4-byte LE word count N, N*4 payload bytes (LE words), 1 checksum byte
// equal to the sum of all payload bytes mod 256 (header excluded).
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx_data_i     incoming byte
//   rx_valid_i    rx_data_i valid
//   rx_ready_o    loader accepts a byte this cycle (combinational from state)
//   restart_i     re-run the load from DONE or ERROR
//   imem_we_o     one-cycle instruction memory write strobe
//   imem_addr_o   word-aligned byte address of the write
//   imem_wdata_o  word to write
//   core_rst_n_o  active-low core reset, released only after a good load
//   load_done_o   high while in DONE
//   load_err_o    high while in ERROR
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | one-cycle pause before a load starts
// S_HDR   | collecting the 4-byte word count
// S_DATA  | collecting payload bytes, one memory write per 4 bytes
// S_CSUM  | collecting the checksum byte
// S_DONE  | image verified, core released
// S_ERROR | bad word count or checksum, core held in reset
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rx_data_i,
    input  logic            rx_valid_i,
    output logic            rx_ready_o,
    input  logic            restart_i,
    output logic            imem_we_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic [XLEN-1:0] imem_wdata_o,
    output logic            core_rst_n_o,
    output logic            load_done_o,
    output logic            load_err_o
);

    localparam int IDX_W = $clog2(MEM_SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       byte_cnt_q;
    logic [31:0]      n_words_q;
    logic [IDX_W-1:0] word_idx_q;
    logic [7:0]       sum_q;
    logic [23:0]      word_buf_q;

    logic             xfer;
    logic             last_byte;
    logic             last_word;
    logic             hdr_bad;
    logic [31:0]      hdr_word;

    assign rx_ready_o = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign xfer       = rx_valid_i && rx_ready_o;
    assign last_byte  = (byte_cnt_q == 2'd3);

    // Full header as it will look once the byte on the bus is taken.
    assign hdr_word   = {rx_data_i, n_words_q[23:0]};
    assign hdr_bad    = (hdr_word == 32'd0) || (hdr_word > 32'(MEM_SIZE));
    assign last_word  = (32'(word_idx_q) == (n_words_q - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_HDR;
            S_HDR: begin
                if (xfer && last_byte) begin
                    state_d = hdr_bad ? S_ERROR : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer && last_byte && last_word) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (rx_data_i == sum_q) ? S_DONE : S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (restart_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q   <= 2'd0;
            n_words_q    <= 32'd0;
            word_idx_q   <= '0;
            sum_q        <= 8'd0;
            word_buf_q   <= 24'd0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            core_rst_n_o <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            imem_we_o    <= 1'b0;
            // Status flags are registered copies of the next state so they
            // change in the cycle right after the deciding edge.
            core_rst_n_o <= (state_d == S_DONE);
            load_done_o  <= (state_d == S_DONE);
            load_err_o   <= (state_d == S_ERROR);

            if (state_q == S_IDLE) begin
                byte_cnt_q <= 2'd0;
            end

            if (xfer) begin
                case (state_q)
                    S_HDR: begin
                        case (byte_cnt_q)
                            2'd0:    n_words_q[7:0]   <= rx_data_i;
                            2'd1:    n_words_q[15:8]  <= rx_data_i;
                            2'd2:    n_words_q[23:16] <= rx_data_i;
                            default: n_words_q[31:24] <= rx_data_i;
                        endcase
                        // Counter wraps 3 -> 0, ready for the first payload byte.
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (last_byte) begin
                            word_idx_q <= '0;
                            sum_q      <= 8'd0;
                        end
                    end
                    S_DATA: begin
                        sum_q      <= sum_q + rx_data_i;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_buf_q[7:0]   <= rx_data_i;
                            2'd1: word_buf_q[15:8]  <= rx_data_i;
                            2'd2: word_buf_q[23:16] <= rx_data_i;
                            default: begin
                                imem_we_o    <= 1'b1;
                                imem_addr_o  <= XLEN'({word_idx_q, 2'b00});
                                imem_wdata_o <= XLEN'({rx_data_i, word_buf_q});
                                word_idx_q   <= word_idx_q + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
